// File: rtl/amux_scan_sequencer_if.sv
// Handshake bundle between the scan sequencer, the analog switch bank and the ADC control.
// The master side is the sequencer; the slave side is the controller/ADC.
interface amux_scan_sequencer_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic              start;
  logic              continuous;
  logic              eoc;
  logic [NUM_CH-1:0] sel;
  logic              soc;
  logic [CH_W-1:0]   ch_id;
  logic              busy;
  logic              eos;

  modport master (
    input  enable, start, continuous, eoc,
    output sel, soc, ch_id, busy, eos
  );

  modport slave (
    output enable, start, continuous, eoc,
    input  sel, soc, ch_id, busy, eos
  );
endinterface

// File: rtl/amux_scan_sequencer.sv
// Walks a one-hot analog switch bank through break / settle / convert for every channel,
// issuing soc after settling and advancing on eoc; enable low aborts, reset_n clears asynchronously.
module amux_scan_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                   clock,
  input logic                   reset_n,
  amux_scan_sequencer_if.master bus
);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;

  localparam logic [7:0]      SETTLE_LD = 8'(SETTLE_EFF - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BREAK   = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CONVERT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              soc_q, soc_d;
  logic              busy_q, busy_d;
  logic              eos_q, eos_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ch_d    = ch_q;
    soc_d   = 1'b0;
    eos_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        ch_d  = '0;
        if (bus.enable && bus.start) begin
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        // Switch closes on leaving BREAK; soc lands in the last settle cycle.
        sel_d   = NUM_CH'(1) << ch_q;
        cnt_d   = SETTLE_LD;
        soc_d   = (SETTLE_LD == 8'd0);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q - 8'd1;
          soc_d = (cnt_q == 8'd1);
        end
      end
      S_CONVERT: begin
        if (bus.eoc) begin
          sel_d = '0;
          if (ch_q == LAST_CH) begin
            eos_d   = 1'b1;
            ch_d    = '0;
            state_d = bus.continuous ? S_BREAK : S_IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_BREAK;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        ch_d    = '0;
      end
    endcase

    // Abort wins over any eoc seen in the same cycle and never reports end-of-scan.
    if (!bus.enable && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      ch_d    = '0;
      soc_d   = 1'b0;
      eos_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ch_q    <= '0;
      soc_q   <= 1'b0;
      busy_q  <= 1'b0;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      soc_q   <= soc_d;
      busy_q  <= busy_d;
      eos_q   <= eos_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.soc   = soc_q;
  assign bus.ch_id = ch_q;
  assign bus.busy  = busy_q;
  assign bus.eos   = eos_q;
endmodule

// File: doc/amux_scan_sequencer.md
Name: amux_scan_sequencer

Overview:
Time-multiplexes a wide analog input bus onto a single shared analog channel, such as one SAR ADC input. It drives one-hot switch enables for NUM_CH analog switches and sequences break-before-make, settling, conversion start and end-of-conversion handshakes. It sits between an analog mux fabric and the ADC control logic, and is used wherever a multi-channel bus must be reduced to a narrower bus over time.

Parameters:
NUM_CH, 4, number of input channels (2..32)
SETTLE_CYCLES, 2, clock cycles a switch is closed before SOC (1..255; 0 is treated as 1)
CH_W, clog2(NUM_CH), width of channel index (derived, not overridden)

Ports:
clock  input  1  block clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  block enable; low aborts any scan
start  input  1  level-sampled scan request, honoured only in IDLE
continuous  input  1  when 1, restart scan automatically after the last channel
eoc  input  1  end-of-conversion pulse from ADC
sel  output  NUM_CH  one-hot analog switch enables; all-zero means disconnected
soc  output  1  start-of-conversion, one-cycle pulse
ch_id  output  CH_W  index of the currently connected or converting channel
busy  output  1  high in every state except IDLE
eos  output  1  end-of-scan, one-cycle pulse

Behaviour:
- All outputs are registered.
- Reset values: sel=0, soc=0, ch_id=0, busy=0, eos=0, state=IDLE, settle counter=0.
- States: IDLE, BREAK, SETTLE, CONVERT.
- IDLE:
  - sel=0, busy=0.
  - enable&start -> BREAK with ch_id=0.
- BREAK:
  - Exactly 1 cycle with sel=0 (break-before-make).
  - Load counter=SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - sel=1<<ch_id.
  - Counter decrements each cycle; at 0 go to CONVERT and assert soc for the transition cycle only.
- CONVERT:
  - sel is held.
  - eoc is ignored in the cycle soc is high; it is sampled from the following cycle onward, and the state waits indefinitely.
  - On eoc with ch_id<NUM_CH-1: ch_id increments and the state goes to BREAK.
  - On eoc with ch_id==NUM_CH-1:
    - eos=1 for 1 cycle and ch_id wraps to 0.
    - If continuous&enable, go to BREAK; otherwise go to IDLE.
- Timing: start sampled at edge N gives BREAK in cycle N+1, SETTLE in cycles N+2..N+1+SETTLE_CYCLES, and soc high at cycle N+1+SETTLE_CYCLES (last SETTLE cycle).
- sel is never multi-hot, and is always 0 for at least 1 cycle between different channels.
- enable low in any non-IDLE state:
  - Next state is IDLE with sel=0, soc=0, ch_id=0.
  - No eos is asserted.
  - Abort has priority over eoc in the same cycle.
- start while busy is ignored; no queuing.
- continuous deasserted mid-scan: the current scan completes, then the block goes to IDLE.
- NUM_CH that is not a power of 2: ch_id never exceeds NUM_CH-1.
- reset_n low at any time: the block returns immediately (asynchronously) to reset values, and sel=0 within the same cycle.

Test Plan:
- NUM_CH=4, SETTLE_CYCLES=2, single scan: start pulse, eoc returned 3 cycles after each soc -> sel sequence 0,0001,0001,0,0010,…,1000 then 0; 4 soc pulses; ch_id 0..3; one eos; busy falls after eos.
- continuous=1 with 2 scans, then continuous cleared during channel 2 of scan 2 -> exactly 2 eos pulses and a return to IDLE; sel never multi-hot across the wrap from channel 3 to channel 0.
- eoc asserted in the same cycle as soc and again 2 cycles later -> the first eoc is ignored and advance happens on the second.
- enable dropped during SETTLE of channel 1, then reasserted with start -> IDLE next cycle, sel=0, no eos; new scan begins at ch_id=0.
- reset_n pulsed low mid-CONVERT on channel 2 -> sel=0, busy=0, ch_id=0 immediately; start after release runs a full scan.
- SETTLE_CYCLES=0, NUM_CH=3 -> behaves as SETTLE_CYCLES=1; ch_id sequence 0,1,2,0; soc exactly 1 cycle after BREAK ends.
